mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sole owner of the byte-wide RAM port. Arbitrates between instruction-fetch requests (from IQ)
//  and load/store requests (from SLB), then sequences each 1/2/4-byte access into single-byte
//  RAM cycles. Returns assembled little-endian data with a one-cycle done pulse.
//  Sits between IQ/SLB and the RAM; the ROB exception line aborts speculative reads.
// PARAMETERS
//  ADDR_W      32  address width (RAM and requesters)
//  DATA_W      32  request data width; fixed at 4 bytes
//  STARVE_MAX  4   consecutive SLB wins allowed while IF waits; then IF is forced
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-high
//  flush         in   1       ROB exception; aborts in-flight reads and drops pending requests
//  if_req_valid  in   1       IQ fetch request; held until if_grant seen
//  if_req_addr   in   ADDR_W  fetch address; always a 4-byte read
//  if_grant      out  1       1-cycle pulse: fetch request accepted and latched
//  if_done       out  1       1-cycle pulse: if_data valid
//  if_data       out  DATA_W  fetched word; held until next if_done
//  ls_req_valid  in   1       SLB request; held until ls_grant seen
//  ls_req_store  in   1       1 = store, 0 = load
//  ls_req_size   in   2       0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
//  ls_req_addr   in   ADDR_W  byte address
//  ls_req_wdata  in   DATA_W  store data; low bytes are used
//  ls_grant      out  1       1-cycle pulse: SLB request accepted and latched
//  ls_done       out  1       1-cycle pulse: load data valid / store fully written
//  ls_rdata      out  DATA_W  load data, zero-extended (the SLB sign-extends); held until next ls_done
//  mem_din       in   8       RAM read byte; valid 1 cycle after its address
//  mem_a         out  ADDR_W  RAM byte address
//  mem_dout      out  8       RAM write byte
//  mem_wr        out  1       RAM write enable
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; starve counter 0; byte counter 0. Async reset overrides mid-access.
//  FSM states: IDLE, RD (IF or LS read), WR (LS store). Owner flag (IF/LS) latched at grant.
//  Arbitration (IDLE only, sampled at edge E0; flush low):
//   - only one valid: grant it
//   - both valid: LS wins unless starve == STARVE_MAX; then IF wins
//   - starve increments on an LS win while if_req_valid is high; clears on any IF grant
//  Grant: at E0, the grant pulse is set, addr/size/wdata are latched, and the state moves to RD or WR.
//   - mem_a is set to base (byte 0) and byte count n = 1, 2 or 4 (IF always 4)
//  RD: the address for byte i is driven in cycle E_i..E_{i+1}, mem_a = base+i (ADDR_W wrap).
//   - mem_din is captured at E_{i+1} into bits [8i+7:8i]
//   - at E_n: done pulse, data register updated (upper unused bytes 0), state IDLE
//   - word read: done 4 edges after grant edge
//  WR: mem_wr = 1 with mem_a = base+i and mem_dout = wdata[8i+7:8i] for cycles i = 0..n-1.
//   - at E_n: mem_wr = 0, ls_done pulse, state IDLE
//  In IDLE: mem_wr = 0, mem_a = 0, mem_dout = 0.
//  The done edge leaves IDLE, so the earliest next grant is the following edge (1 idle cycle min).
//   - valid is ignored outside IDLE, so no double grant while a requester drops valid.
//  Flush (level, sampled each edge):
//   - IDLE: no grant that edge; starve counter cleared
//   - RD: abort to IDLE next edge; no done; data registers unchanged
//   - WR: ignored; the store already committed by ROB completes all bytes and pulses ls_done
//  Grant and done are never both high for the same requester in the same cycle.
//  A 2-byte access at base 0xFFFFFFFF wraps to 0x0.
// TESTING
//  1 Assert rst mid word-read -> all outputs 0 immediately. After release with no valids -> mem_wr = 0, mem_a = 0 indefinitely.
//  2 IF read 0x100, RAM[0x100..0x103] = 13,05,50,00
//    -> mem_a 0x100..0x103 on successive cycles; if_done 4 edges after if_grant; if_data = 0x00500513.
//  3 SH 0xDEADBEEF @0x2002 -> mem_wr high 2 cycles: (0x2002, EF), (0x2003, BE); then ls_done; RAM[0x2004] untouched.
//  4 Both valid continuously, STARVE_MAX = 4 -> grant order LS, LS, LS, LS, IF, LS...; starve resets after the IF grant.
//  5 Flush 2 cycles into an IF read -> no if_done, IDLE next edge.
//    Flush during SW -> all 4 bytes written, ls_done pulses.
//  6 LB @0x300 with RAM = 0x80 -> ls_rdata = 0x00000080 one edge after the grant edge; LW at 0x3FFFFFFE...
//    mem_a wraps correctly through 0x40000001.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM port. Arbitrates IQ fetches against SLB
// loads/stores and splits each 1/2/4-byte access into single-byte RAM cycles.
//
// state | meaning
// IDLE  | nothing in flight; arbitration and grant happen here
// RD    | reading bytes for the latched owner (IF or LS), assembling little-endian
// WR    | writing LS store bytes, one per cycle
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_grant,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_store,
  input  logic [1:0]        ls_req_size,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_grant,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              if_grant_q, if_grant_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              ls_grant_q, ls_grant_d;
  logic              ls_done_q, ls_done_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic              arb_if, arb_ls;
  logic              last_byte;
  logic [1:0]        cnt_nx;
  logic [1:0]        ls_last;
  logic [DATA_W-1:0] rd_merge;

  // IF only beats a waiting LS once it has been passed over STARVE_MAX times
  always_comb begin
    arb_if = 1'b0;
    arb_ls = 1'b0;
    if (state_q == S_IDLE && !flush) begin
      arb_if = if_req_valid && (!ls_req_valid || starve_q == STARVE_LIM);
      arb_ls = ls_req_valid && !arb_if;
    end
  end

  always_comb begin
    case (ls_req_size)
      2'd0:    ls_last = 2'd0;
      2'd1:    ls_last = 2'd1;
      default: ls_last = 2'd3;
    endcase
  end

  assign last_byte = (cnt_q == last_q);
  assign cnt_nx    = cnt_q + 2'd1;

  always_comb begin
    rd_merge = rd_buf_q;
    rd_merge[{cnt_q, 3'b000} +: 8] = mem_din;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arb_if)      state_d = S_RD;
        else if (arb_ls) state_d = ls_req_store ? S_WR : S_RD;
      end
      S_RD:    if (flush || last_byte) state_d = S_IDLE;
      S_WR:    if (last_byte) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output and datapath logic
  always_comb begin
    owner_ls_d = owner_ls_q;
    base_d     = base_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rd_buf_d   = rd_buf_q;
    starve_d   = starve_q;
    if_grant_d = 1'b0;
    if_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_grant_d = 1'b0;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;

    case (state_q)
      S_IDLE: begin
        mem_a_d    = '0;
        mem_dout_d = '0;
        mem_wr_d   = 1'b0;
        if (flush || arb_if)             starve_d = '0;
        else if (arb_ls && if_req_valid) starve_d = starve_q + SW'(1);

        if (arb_if) begin
          if_grant_d = 1'b1;
          owner_ls_d = 1'b0;
          base_d     = if_req_addr;
          last_d     = 2'd3;
          cnt_d      = '0;
          rd_buf_d   = '0;
          mem_a_d    = if_req_addr;
        end else if (arb_ls) begin
          ls_grant_d = 1'b1;
          owner_ls_d = 1'b1;
          base_d     = ls_req_addr;
          last_d     = ls_last;
          cnt_d      = '0;
          rd_buf_d   = '0;
          wdata_d    = ls_req_wdata;
          mem_a_d    = ls_req_addr;
          if (ls_req_store) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = ls_req_wdata[7:0];
          end
        end
      end

      S_RD: begin
        if (flush) begin
          mem_a_d = '0;
          cnt_d   = '0;
        end else if (last_byte) begin
          mem_a_d = '0;
          cnt_d   = '0;
          if (owner_ls_q) begin
            ls_done_d  = 1'b1;
            ls_rdata_d = rd_merge;
          end else begin
            if_done_d = 1'b1;
            if_data_d = rd_merge;
          end
        end else begin
          rd_buf_d = rd_merge;
          cnt_d    = cnt_nx;
          mem_a_d  = base_q + ADDR_W'(cnt_nx);
        end
      end

      // flush is deliberately ignored: a store reaching WR is already committed
      S_WR: begin
        if (last_byte) begin
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          mem_dout_d = '0;
          cnt_d      = '0;
          ls_done_d  = 1'b1;
        end else begin
          cnt_d      = cnt_nx;
          mem_a_d    = base_q + ADDR_W'(cnt_nx);
          mem_dout_d = wdata_q[{cnt_nx, 3'b000} +: 8];
        end
      end

      default: begin
        mem_a_d    = '0;
        mem_dout_d = '0;
        mem_wr_d   = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_ls_q <= 1'b0;
      base_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      starve_q   <= '0;
      if_grant_q <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_grant_q <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      owner_ls_q <= owner_ls_d;
      base_q     <= base_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rd_buf_q   <= rd_buf_d;
      starve_q   <= starve_d;
      if_grant_q <= if_grant_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      ls_grant_q <= ls_grant_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign if_grant = if_grant_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_grant = ls_grant_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed accesses against a byte RAM model; expected
// addresses, data and grant order come from the access rules, not from the DUT.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_grant, if_done;
  logic [31:0] if_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_store = 1'b0;
  logic [1:0]  ls_req_size = '0;
  logic [31:0] ls_req_addr = '0;
  logic [31:0] ls_req_wdata = '0;
  logic        ls_grant, ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_if_data = '0;
  logic [31:0] m_ls_rdata = '0;
  int          m_starve = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_grant(if_grant), .if_done(if_done), .if_data(if_data),
    .ls_req_valid(ls_req_valid), .ls_req_store(ls_req_store), .ls_req_size(ls_req_size),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_grant(ls_grant), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM aliases on the low 16 address bits; read data is valid while its address is driven
  assign mem_din = ram[mem_a[15:0]];
  always @(posedge clk) begin
    if (mem_wr)     ram[mem_a[15:0]] <= mem_dout;
    else if (tb_we) ram[tb_wa] <= tb_wd;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    tb_wa = a[15:0];
    tb_wd = d;
    tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
  endtask

  // One access from a single requester; flush_at >= 0 raises flush in that access cycle
  task automatic do_access(input bit is_if, input bit st, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rbytes, input int flush_at);
    int          n;
    logic [31:0] exp;
    logic [31:0] ai;
    logic [7:0]  after_byte;
    bit          got;
    bit          aborted;
    n = is_if ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp = '0;
    if (!st) begin
      for (int i = 0; i < n; i++) begin
        poke(addr + 32'(i), rbytes[8*i +: 8]);
        exp[8*i +: 8] = rbytes[8*i +: 8];
      end
    end
    ai = addr + 32'(n);
    after_byte = ram[ai[15:0]];
    if (is_if) begin
      if_req_valid = 1'b1;
      if_req_addr  = addr;
    end else begin
      ls_req_valid = 1'b1;
      ls_req_store = st;
      ls_req_size  = sz;
      ls_req_addr  = addr;
      ls_req_wdata = wd;
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      got = is_if ? if_grant : ls_grant;
    end
    check_val("grant", 32'(got), 32'd1);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    if (!got) return;
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_val("mem_a", mem_a, addr + 32'(i));
      check_val("mem_wr", 32'(mem_wr), 32'(st));
      if (st) check_val("mem_dout", 32'(mem_dout), 32'(wd[8*i +: 8]));
      check_val("done_early", 32'(is_if ? if_done : ls_done), 32'd0);
      if (i == flush_at) flush = 1'b1;
      tick();
      if (flush && !st) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      flush = 1'b0;
      check_val("flush_mem_a", mem_a, 32'd0);
      for (int c = 0; c < 5; c++) begin
        check_val("flush_no_done", 32'(is_if ? if_done : ls_done), 32'd0);
        tick();
      end
      check_val("flush_data_kept", is_if ? if_data : ls_rdata, is_if ? m_if_data : m_ls_rdata);
      return;
    end
    flush = 1'b0;
    check_val("done", 32'(is_if ? if_done : ls_done), 32'd1);
    check_val("idle_wr", 32'(mem_wr), 32'd0);
    check_val("idle_a", mem_a, 32'd0);
    if (st) begin
      for (int i = 0; i < n; i++) begin
        ai = addr + 32'(i);
        check_val("ram_byte", 32'(ram[ai[15:0]]), 32'(wd[8*i +: 8]));
      end
      ai = addr + 32'(n);
      check_val("ram_untouched", 32'(ram[ai[15:0]]), 32'(after_byte));
      check_val("rdata_kept", ls_rdata, m_ls_rdata);
    end else if (is_if) begin
      m_if_data = exp;
      check_val("if_data", if_data, exp);
    end else begin
      m_ls_rdata = exp;
      check_val("ls_rdata", ls_rdata, exp);
    end
    tick();
    check_val("done_pulse", 32'(is_if ? if_done : ls_done), 32'd0);
    check_val("data_held", is_if ? if_data : ls_rdata, is_if ? m_if_data : m_ls_rdata);
  endtask

  task automatic run_both(input int ng_want);
    int ng;
    bit exp_if;
    ng = 0;
    if_req_addr  = 32'h500;
    ls_req_store = 1'b0;
    ls_req_size  = 2'd0;
    ls_req_addr  = 32'h600;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    for (int c = 0; c < 400 && ng < ng_want; c++) begin
      tick();
      check_val("gd_if", 32'(if_grant & if_done), 32'd0);
      check_val("gd_ls", 32'(ls_grant & ls_done), 32'd0);
      if (if_grant || ls_grant) begin
        exp_if = (m_starve == STARVE_MAX);
        check_val("arb_if_win", 32'(if_grant), 32'(exp_if));
        check_val("arb_ls_win", 32'(ls_grant), 32'(!exp_if));
        m_starve = exp_if ? 0 : m_starve + 1;
        ng++;
      end
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    check_val("arb_count", 32'(ng), 32'(ng_want));
    repeat (8) tick();
  endtask

  initial begin
    bit          is_if, st;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rb;
    int          fa;

    repeat (3) tick();
    check_val("rst_mem_a", mem_a, 32'd0);
    check_val("rst_flags", {27'd0, if_grant, if_done, ls_grant, ls_done, mem_wr}, 32'd0);
    rst = 1'b0;
    tick();

    do_access(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, 32'h00500513, -1);
    check_val("if_word_0x100", if_data, 32'h00500513);
    poke(32'h2004, 8'h5A);
    do_access(1'b0, 1'b1, 2'd1, 32'h2002, 32'hDEADBEEF, 32'd0, -1);
    check_val("sh_0x2004", 32'(ram[16'h2004]), 32'h5A);
    do_access(1'b0, 1'b0, 2'd0, 32'h300, 32'd0, 32'h00000080, -1);
    check_val("lb_0x300", ls_rdata, 32'h00000080);
    do_access(1'b0, 1'b0, 2'd2, 32'h3FFFFFFE, 32'd0, 32'hA1B2C3D4, -1);
    do_access(1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd0, 32'h00007788, -1);

    // async reset in the middle of a word read
    ls_req_valid = 1'b1;
    ls_req_store = 1'b0;
    ls_req_size  = 2'd2;
    ls_req_addr  = 32'h700;
    tick();
    check_val("rst_mid_grant", 32'(ls_grant), 32'd1);
    ls_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("rst_mid_flags", {27'd0, if_grant, if_done, ls_grant, ls_done, mem_wr}, 32'd0);
    check_val("rst_mid_a", mem_a, 32'd0);
    check_val("rst_mid_dout", 32'(mem_dout), 32'd0);
    check_val("rst_mid_if_data", if_data, 32'd0);
    check_val("rst_mid_ls_rdata", ls_rdata, 32'd0);
    m_if_data  = '0;
    m_ls_rdata = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("post_rst_idle", {mem_wr, mem_a[30:0]}, 32'd0);
    end

    // starvation: LS x4 then IF, repeating
    for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i), 8'(8'h11 * (i + 1)));
    poke(32'h600, 8'hC7);
    m_if_data  = 32'h44332211;
    m_ls_rdata = 32'h000000C7;
    m_starve   = 0;
    run_both(12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_starve = 0;
    run_both(5);
    check_val("starve_if_data", if_data, m_if_data);
    check_val("starve_ls_rdata", ls_rdata, m_ls_rdata);

    // flush in IDLE holds off a pending request
    ls_req_valid = 1'b1;
    ls_req_store = 1'b0;
    ls_req_size  = 2'd0;
    ls_req_addr  = 32'h600;
    flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("flush_idle_no_grant", 32'(ls_grant), 32'd0);
    end
    flush = 1'b0;
    tick();
    check_val("grant_after_flush", 32'(ls_grant), 32'd1);
    ls_req_valid = 1'b0;
    repeat (4) tick();

    do_access(1'b1, 1'b0, 2'd2, 32'h800, 32'd0, 32'h12345678, 1);
    do_access(1'b0, 1'b1, 2'd2, 32'h900, 32'hCAFEF00D, 32'd0, 1);

    for (int t = 0; t < 40; t++) begin
      is_if = ($urandom_range(0, 2) == 0);
      st    = !is_if && ($urandom_range(0, 1) == 1);
      sz    = 2'($urandom_range(0, 3));
      addr  = $urandom;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      wd    = $urandom;
      rb    = $urandom;
      fa    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_access(is_if, st, sz, addr, wd, rb, fa);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
